glb_wr_pack: RTL and testbench
==============================

GLB_WR_PACK -- requirements
Module: glb_wr_pack

Interface
REQ-001 Param SRAM_WIDTH, 256, width of one narrow input word (= one bank word).
REQ-002 Param MAXPAR, 32, max words packed per output beat (= GLB write-port MAXPAR).
REQ-003 Param ADDR_WIDTH, 16, beat-counter width.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 CfgRst  in  1  synchronous clear; relatches config.
REQ-007 CfgParBank  in  $clog2(MAXPAR)+1  words per output beat.
REQ-008 CfgBeatMax  in  ADDR_WIDTH  last beat index of the transfer.
REQ-009 InDat  in  SRAM_WIDTH  narrow input word.
REQ-010 InDatVld / InDatRdy  in / out  1 each  input handshake.
REQ-011 InDatLast  in  1  marks the final word of a transfer; flushes a partial beat.
REQ-012 OutDat  out  SRAM_WIDTH*MAXPAR  packed beat; feeds one GLB write port.
REQ-013 OutDatVld / OutDatRdy  out / in  1 each  output handshake.
REQ-014 BeatCnt  out  ADDR_WIDTH, Fnh  out  1  (only with macro, see REQ-033).

Function
REQ-015 Input transfer occurs when InDatVld & InDatRdy; output transfer occurs when OutDatVld & OutDatRdy.
REQ-016 Accepted word k of a beat shall occupy lane k, i.e. bits [SRAM_WIDTH*k +: SRAM_WIDTH]; lane index counts 0..Par-1.
REQ-017 Par shall be the CfgParBank value latched on reset release or CfgRst; 0 is treated as 1, values >MAXPAR are clamped to MAXPAR.
REQ-018 A beat completes on the word that fills lane Par-1, or on any word with InDatLast=1.
REQ-019 Lanes not written in a completed beat shall be zero.
REQ-020 Datapath: one pack register and one output register; a completed beat moves to the output register on the accepting edge when the output register is empty or drains in the same cycle.
REQ-021 Latency: the completing word accepted at edge t gives OutDatVld=1 from cycle t+1.
REQ-022 If the output register is full and not draining, the completed beat waits in the pack register. InDatRdy shall be 0 while the pack register holds a completed beat. It returns to 1 in the cycle after the beat moves out.
REQ-023 InDatRdy shall not depend combinationally on InDatVld. Its only combinational input from the output side is OutDatRdy.
REQ-024 Throughput: with OutDatRdy held at 1, the block shall accept one word every cycle with no bubbles, including Par=1.
REQ-025 OutDat and OutDatVld shall stay stable while OutDatVld=1 and OutDatRdy=0.
REQ-026 FSM states:
- IDLE: empty.
- FILL: a partial beat is held.
- FULL: a completed beat is held and InDatRdy=0.
REQ-027 FSM transitions:
- IDLE->FILL on the first word, unless that word completes the beat.
- FILL->IDLE when the beat completes and moves to the output register.
- FILL->FULL when the beat completes while blocked.
- FULL->IDLE when the beat moves out.
REQ-028 CfgRst shall clear both registers, the lane index, OutDatVld and BeatCnt in the next cycle, even mid-transfer. Any in-flight data is discarded.
REQ-029 When InDatLast and lane Par-1 coincide, the block shall emit exactly one beat.

Reset
REQ-030 On rst_n=0: state IDLE, lane index 0, OutDat 0, OutDatVld 0, BeatCnt 0, Fnh 0. InDatRdy shall be 0 during reset and 1 in the first cycle after release.
REQ-031 Reset shall be asynchronous assert and synchronous deassert, applied via rst_n only.

Configuration
REQ-032 Feature macro GLB_WR_PACK_BEATCNT_EN.
REQ-033 Macro defined:
- BeatCnt increments on each output transfer.
- Fnh pulses for 1 cycle on the output transfer where BeatCnt==CfgBeatMax; BeatCnt then wraps to 0.
REQ-034 Macro undefined: BeatCnt and Fnh ports and their logic are absent, and CfgBeatMax is ignored.

Structure
REQ-035 The shared GLB package holds:
- FSM state encodings (IDLE/FILL/FULL);
- the default SRAM_WIDTH, MAXPAR and ADDR_WIDTH constants;
- the par-clamp function.
REQ-036 One sub-module: the existing shared counter, used for BeatCnt. There are no other sub-modules.

Verification
REQ-037 Par=4, OutDatRdy=1, words 1..8 back-to-back -> two beats: lanes 0-3 = 1..4, then 5..8. OutDatVld is high at cycles 5 and 9 (first word at cycle 1). InDatRdy stays 1.
REQ-038 Par=4, words A,B,C with Last on C -> one beat, lanes 0-2 = A,B,C, lanes 3..31 = 0.
REQ-039 Par=2, OutDatRdy=0 for 6 cycles, input always valid:
- 4 words are accepted, then InDatRdy=0.
- OutDat stays stable while blocked.
- After OutDatRdy=1, beats drain in order with no loss.
REQ-040 CfgParBank=0 -> 1 word per beat; CfgParBank=40 -> 32 words per beat.
REQ-041 CfgRst asserted mid-beat after 2 of 4 words -> OutDatVld 0 next cycle. The next 4 words form a clean beat starting at lane 0.
REQ-042 Macro on, CfgBeatMax=2, Par=1, 4 words -> Fnh pulses on the 3rd output transfer; BeatCnt reads 0,1,2,0.

Source files
------------

// File: rtl/glb_wr_pack_pkg.sv
// Shared GLB types and constants for the write-port packer.
// Holds the packer FSM encoding, the default geometry constants and the
// helper that clamps a requested parallelism into the legal 1..MAXPAR range.
package glb_wr_pack_pkg;

  localparam int SRAM_WIDTH_DEF = 256;
  localparam int MAXPAR_DEF     = 32;
  localparam int ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // pack register empty
    ST_FILL = 2'd1,  // partial beat held
    ST_FULL = 2'd2   // completed beat held, input stalled
  } state_e;

  // Requested words-per-beat -> legal lane count (0 means 1, large clamps).
  function automatic int unsigned par_clamp(input int unsigned raw,
                                            input int unsigned maxpar);
    if (raw == 0) begin
      return 1;
    end else if (raw > maxpar) begin
      return maxpar;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/glb_wr_pack_cnt.sv
// Shared wrap-around counter: counts increments, wraps to 0 after max_i.
// Latency: cnt_o is registered; wrap_o is combinational on the wrapping inc_i.
// Backpressure: none; inc_i is a qualified event, clr_i wins over inc_i.
// Ports: clk/rst_n clock and async reset, clr_i sync clear, inc_i count
//        event, max_i last count value, cnt_o current count, wrap_o pulse.
module glb_wr_pack_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign wrap_o = inc_i & (cnt_q == max_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/glb_wr_pack.sv
// Packs narrow SRAM words into one wide GLB write beat (lane k = k-th word).
// Latency: completing word accepted at edge t -> OutDatVld from cycle t+1.
// Backpressure: a completed beat blocked by a full output register parks in
//   the pack register and drops InDatRdy until it moves out.
// Ports: clk, rst_n (async active-low); CfgRst sync clear + config relatch;
//   CfgParBank words per beat; CfgBeatMax last beat index; InDat/InDatVld/
//   InDatRdy/InDatLast narrow input; OutDat/OutDatVld/OutDatRdy wide output;
//   BeatCnt/Fnh beat counter and end-of-transfer pulse.
// Optional feature macro: GLB_WR_PACK_BEATCNT_EN adds BeatCnt/Fnh.
module glb_wr_pack
  import glb_wr_pack_pkg::*;
#(
  parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
  parameter int MAXPAR     = MAXPAR_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         CfgRst,
  input  logic [$clog2(MAXPAR):0]      CfgParBank,
  input  logic [ADDR_WIDTH-1:0]        CfgBeatMax,
  input  logic [SRAM_WIDTH-1:0]        InDat,
  input  logic                         InDatVld,
  output logic                         InDatRdy,
  input  logic                         InDatLast,
  output logic [SRAM_WIDTH*MAXPAR-1:0] OutDat,
  output logic                         OutDatVld,
  input  logic                         OutDatRdy
`ifdef GLB_WR_PACK_BEATCNT_EN
  ,
  output logic [ADDR_WIDTH-1:0]        BeatCnt,
  output logic                         Fnh
`endif
);

  localparam int PW = $clog2(MAXPAR) + 1;
  localparam int LW = (MAXPAR > 1) ? $clog2(MAXPAR) : 1;
  localparam int OW = SRAM_WIDTH * MAXPAR;

  state_e          state_q;
  logic [LW-1:0]   lane_q;
  logic [PW-1:0]   par_q;
  logic [OW-1:0]   pack_q;
  logic [OW-1:0]   pack_d;
  logic [OW-1:0]   out_q;
  logic            out_vld_q;
  // Low through reset and the edge that releases it; gates InDatRdy and
  // marks the cycle in which configuration is first latched.
  logic            rdy_en_q;

  logic [PW-1:0]   par_new;
  logic            in_fire;
  logic            out_drain;
  logic            out_free;
  logic            last_lane;
  logic            beat_done;

  assign par_new   = PW'(par_clamp(32'(CfgParBank), MAXPAR));
  assign InDatRdy  = rdy_en_q & (state_q != ST_FULL);
  assign in_fire   = InDatVld & InDatRdy;
  assign out_drain = out_vld_q & OutDatRdy;
  // Output register can take a beat this edge: empty, or emptying now.
  assign out_free  = ~out_vld_q | OutDatRdy;
  assign last_lane = ((PW'(lane_q) + PW'(1)) == par_q);
  assign beat_done = in_fire & (last_lane | InDatLast);

  // Current pack contents with the incoming word dropped into its lane.
  // Unwritten lanes stay zero because the pack register is cleared on
  // every beat completion.
  always_comb begin
    pack_d = pack_q;
    for (int k = 0; k < MAXPAR; k++) begin
      if (lane_q == LW'(k)) begin
        pack_d[k*SRAM_WIDTH +: SRAM_WIDTH] = InDat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      par_q     <= PW'(1);
      pack_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else if (CfgRst) begin
      state_q   <= ST_IDLE;
      lane_q    <= '0;
      par_q     <= par_new;
      pack_q    <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      rdy_en_q  <= 1'b1;
    end else begin
      rdy_en_q <= 1'b1;
      if (!rdy_en_q) begin
        par_q <= par_new;
      end
      case (state_q)
        ST_FULL: begin
          // Parked beat leaves as soon as the output register has room.
          if (out_free) begin
            out_q     <= pack_q;
            out_vld_q <= 1'b1;
            pack_q    <= '0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          if (beat_done) begin
            lane_q <= '0;
            if (out_free) begin
              out_q     <= pack_d;
              out_vld_q <= 1'b1;
              pack_q    <= '0;
              state_q   <= ST_IDLE;
            end else begin
              pack_q  <= pack_d;
              state_q <= ST_FULL;
            end
          end else begin
            if (in_fire) begin
              pack_q  <= pack_d;
              lane_q  <= lane_q + LW'(1);
              state_q <= ST_FILL;
            end
            if (out_drain) begin
              out_vld_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign OutDat    = out_q;
  assign OutDatVld = out_vld_q;

`ifdef GLB_WR_PACK_BEATCNT_EN
  logic [ADDR_WIDTH-1:0] beat_max_q;

  // Transfer length is configuration: latched with the lane count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_max_q <= '0;
    end else if (CfgRst || !rdy_en_q) begin
      beat_max_q <= CfgBeatMax;
    end
  end

  glb_wr_pack_cnt #(
    .WIDTH (ADDR_WIDTH)
  ) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (CfgRst),
    .inc_i  (out_drain),
    .max_i  (beat_max_q),
    .cnt_o  (BeatCnt),
    .wrap_o (Fnh)
  );
`else
  logic unused_cfg_beat_max;
  assign unused_cfg_beat_max = ^CfgBeatMax;
`endif

endmodule

// File: tb/tb_glb_wr_pack.sv
module tb_glb_wr_pack;

  localparam int W  = 256;
  localparam int MP = 32;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              CfgRst;
  logic [5:0]        CfgParBank;
  logic [AW-1:0]     CfgBeatMax;
  logic [W-1:0]      InDat;
  logic              InDatVld;
  logic              InDatRdy;
  logic              InDatLast;
  logic [W*MP-1:0]   OutDat;
  logic              OutDatVld;
  logic              OutDatRdy;
`ifdef GLB_WR_PACK_BEATCNT_EN
  logic [AW-1:0]     BeatCnt;
  logic              Fnh;
`endif

  glb_wr_pack #(.SRAM_WIDTH(W), .MAXPAR(MP), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .CfgRst     (CfgRst),
    .CfgParBank (CfgParBank),
    .CfgBeatMax (CfgBeatMax),
    .InDat      (InDat),
    .InDatVld   (InDatVld),
    .InDatRdy   (InDatRdy),
    .InDatLast  (InDatLast),
    .OutDat     (OutDat),
    .OutDatVld  (OutDatVld),
    .OutDatRdy  (OutDatRdy)
`ifdef GLB_WR_PACK_BEATCNT_EN
    ,
    .BeatCnt    (BeatCnt),
    .Fnh        (Fnh)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          cr;
    logic [5:0]  par;
    bit          vld;
    logic [31:0] dat;
    bit          last;
    bit          ordy;
    bit          e_rdy;
    bit          e_vld;
    logic [31:0] e_l0, e_l1, e_l2, e_l3;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int k);
    return OutDat[k*W +: W];
  endfunction

  task automatic add(input bit cr, input logic [5:0] par, input bit vld,
                     input logic [31:0] dat, input bit last, input bit ordy,
                     input bit e_rdy, input bit e_vld,
                     input logic [31:0] l0 = 0, input logic [31:0] l1 = 0,
                     input logic [31:0] l2 = 0, input logic [31:0] l3 = 0);
    vec_t v;
    v.cr = cr; v.par = par; v.vld = vld; v.dat = dat; v.last = last;
    v.ordy = ordy; v.e_rdy = e_rdy; v.e_vld = e_vld;
    v.e_l0 = l0; v.e_l1 = l1; v.e_l2 = l2; v.e_l3 = l3;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit cr, input logic [5:0] par, input bit vld,
                       input logic [31:0] dat, input bit last, input bit ordy);
    CfgRst     = cr;
    CfgParBank = par;
    InDatVld   = vld;
    InDat      = W'(dat);
    InDatLast  = last;
    OutDatRdy  = ordy;
  endtask

  initial begin
    bit rest_zero;
    bit early_vld;

    // Par=4 back-to-back: beats visible in table cycles 5 and 9.
    for (int i = 1; i <= 4; i++) add(0, 4, 1, i, 0, 1, 1, 0);
    add(0, 4, 1, 5, 0, 1, 1, 1, 1, 2, 3, 4);
    for (int i = 6; i <= 8; i++) add(0, 4, 1, i, 0, 1, 1, 0);
    add(0, 4, 0, 0, 0, 1, 1, 1, 5, 6, 7, 8);
    add(0, 4, 0, 0, 0, 1, 1, 0);
    // Short beat closed by Last.
    add(0, 4, 1, 32'hA, 0, 1, 1, 0);
    add(0, 4, 1, 32'hB, 0, 1, 1, 0);
    add(0, 4, 1, 32'hC, 1, 1, 1, 0);
    add(0, 4, 0, 0, 0, 1, 1, 1, 32'hA, 32'hB, 32'hC, 0);
    add(0, 4, 0, 0, 0, 1, 1, 0);
    // Par=2 with the output blocked for 6 cycles.
    add(1, 2, 0, 0, 0, 1, 1, 0);
    add(0, 2, 1, 32'h11, 0, 0, 1, 0);
    add(0, 2, 1, 32'h12, 0, 0, 1, 0);
    add(0, 2, 1, 32'h13, 0, 0, 1, 1, 32'h11, 32'h12, 0, 0);
    add(0, 2, 1, 32'h14, 0, 0, 1, 1, 32'h11, 32'h12, 0, 0);
    add(0, 2, 1, 32'h15, 0, 0, 0, 1, 32'h11, 32'h12, 0, 0);
    add(0, 2, 1, 32'h15, 0, 0, 0, 1, 32'h11, 32'h12, 0, 0);
    add(0, 2, 1, 32'h15, 0, 1, 0, 1, 32'h11, 32'h12, 0, 0);
    add(0, 2, 1, 32'h15, 0, 1, 1, 1, 32'h13, 32'h14, 0, 0);
    add(0, 2, 1, 32'h16, 0, 1, 1, 0);
    add(0, 2, 0, 0, 0, 1, 1, 1, 32'h15, 32'h16, 0, 0);
    add(0, 2, 0, 0, 0, 1, 1, 0);
    // CfgParBank=0 behaves as one word per beat, no bubbles.
    add(1, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 1, 32'h21, 0, 1, 1, 0);
    add(0, 0, 1, 32'h22, 0, 1, 1, 1, 32'h21, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1, 32'h22, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0);
    // CfgRst mid-beat with an undrained beat in the output register.
    add(1, 4, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 4; i++) add(0, 4, 1, 32'h50 + i, 0, 0, 1, 0);
    add(0, 4, 1, 32'h55, 0, 0, 1, 1, 32'h51, 32'h52, 32'h53, 32'h54);
    add(0, 4, 1, 32'h56, 0, 0, 1, 1, 32'h51, 32'h52, 32'h53, 32'h54);
    add(1, 4, 0, 0, 0, 0, 1, 1, 32'h51, 32'h52, 32'h53, 32'h54);
    add(0, 4, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 4; i++) add(0, 4, 1, 32'h40 + i, 0, 1, 1, 0);
    add(0, 4, 0, 0, 0, 1, 1, 1, 32'h41, 32'h42, 32'h43, 32'h44);
    add(0, 4, 0, 0, 0, 1, 1, 0);

    // Reset state.
    rst_n = 1'b0;
    CfgBeatMax = AW'(2);
    drive(0, 4, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", W'(InDatRdy), W'(0));
    chk("rst_out_vld", W'(OutDatVld), W'(0));
    chk("rst_out_dat", W'(OutDat == '0), W'(1));
`ifdef GLB_WR_PACK_BEATCNT_EN
    chk("rst_beatcnt", W'(BeatCnt), W'(0));
    chk("rst_fnh", W'(Fnh), W'(0));
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].cr, vecs[i].par, vecs[i].vld, vecs[i].dat,
            vecs[i].last, vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d_in_rdy", i), W'(InDatRdy), W'(vecs[i].e_rdy));
      chk($sformatf("v%0d_out_vld", i), W'(OutDatVld), W'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        chk($sformatf("v%0d_lane0", i), lane(0), W'(vecs[i].e_l0));
        chk($sformatf("v%0d_lane1", i), lane(1), W'(vecs[i].e_l1));
        chk($sformatf("v%0d_lane2", i), lane(2), W'(vecs[i].e_l2));
        chk($sformatf("v%0d_lane3", i), lane(3), W'(vecs[i].e_l3));
        rest_zero = (OutDat[W*MP-1:4*W] == '0);
        chk($sformatf("v%0d_lanes4up_zero", i), W'(rest_zero), W'(1));
      end
      @(posedge clk);
      #1;
    end

    // CfgParBank=40 clamps to 32 words per beat.
    drive(1, 40, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    early_vld = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(0, 40, 1, 32'h100 + i, 0, 1);
      @(negedge clk);
      if (OutDatVld || !InDatRdy) early_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    drive(0, 40, 0, 0, 0, 1);
    @(negedge clk);
    chk("par32_no_early_beat", W'(early_vld), W'(0));
    chk("par32_out_vld", W'(OutDatVld), W'(1));
    chk("par32_lane0", lane(0), W'(32'h100));
    chk("par32_lane16", lane(16), W'(32'h110));
    chk("par32_lane31", lane(31), W'(32'h11F));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("par32_drained", W'(OutDatVld), W'(0));
    @(posedge clk);
    #1;

`ifdef GLB_WR_PACK_BEATCNT_EN
    // Par=1, CfgBeatMax=2: BeatCnt 0,1,2,0 at transfers, Fnh on the third.
    begin
      logic [AW-1:0] exp_cnt[4];
      exp_cnt[0] = 0; exp_cnt[1] = 1; exp_cnt[2] = 2; exp_cnt[3] = 0;
      CfgBeatMax = AW'(2);
      drive(1, 1, 0, 0, 0, 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
        drive(0, 1, (i < 4), 32'h60 + i, 0, 1);
        @(negedge clk);
        if (i == 0) chk("cnt_after_cfgrst", W'(BeatCnt), W'(0));
        if (i >= 1 && i <= 4) begin
          chk($sformatf("cnt_xfer%0d_vld", i), W'(OutDatVld), W'(1));
          chk($sformatf("cnt_xfer%0d_beatcnt", i), W'(BeatCnt),
              W'(exp_cnt[i-1]));
          chk($sformatf("cnt_xfer%0d_fnh", i), W'(Fnh), W'(i == 3));
        end
        @(posedge clk);
        #1;
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
